axi_chan_scoreboard: RTL and testbench

- Synthesizable single-clock, in-order scoreboard for NumChan valid/ready channels (e.g. AW, W, B, AR, R).
- Captures each beat accepted at the upstream side of an in-order DUT (register slice, FIFO, same-clock CDC stand-in) into a per-channel FIFO.
- Compares each beat accepted at the downstream side against the FIFO head.
- Counts mismatches and completed transactions, and reports done/fail; used in FPGA self-checking benches and as an embedded bus checker.

---
 rtl/axi_chan_scoreboard_if.sv | 31 +++
 rtl/axi_chan_scoreboard.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_chan_scoreboard.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_chan_scoreboard_if.sv
// ---------------------------------------------------------------------------
// axi_chan_scoreboard_if
// Bundles the monitored handshakes of NumChan valid/ready channels: the
// upstream (src) side feeding an in-order DUT and the downstream (snk) side
// leaving it. Channel c occupies bits [c*DataWidth +: DataWidth] of the data
// vectors.
//   master : drives every signal (bench / traffic side)
//   slave  : observes every signal (the scoreboard is a passive monitor)
// ---------------------------------------------------------------------------
interface axi_chan_scoreboard_if #(
    parameter int NumChan   = 5,
    parameter int DataWidth = 64
);
    logic [NumChan-1:0]           src_valid;
    logic [NumChan-1:0]           src_ready;
    logic [NumChan*DataWidth-1:0] src_data;
    logic [NumChan-1:0]           snk_valid;
    logic [NumChan-1:0]           snk_ready;
    logic [NumChan*DataWidth-1:0] snk_data;
    logic [NumChan-1:0]           snk_last;

    modport master (
        output src_valid, src_ready, src_data,
        output snk_valid, snk_ready, snk_data, snk_last
    );

    modport slave (
        input src_valid, src_ready, src_data,
        input snk_valid, snk_ready, snk_data, snk_last
    );
endinterface

// File: rtl/axi_chan_scoreboard.sv
// ---------------------------------------------------------------------------
// axi_chan_scoreboard
// In-order scoreboard for NumChan valid/ready channels. Beats accepted on the
// src side of each channel are queued in a per-channel FIFO; beats accepted on
// the snk side are compared (under cmp_mask_i) against the FIFO head.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   enable_i            arms the scoreboard; low flushes FIFOs/counters/flags
//   expected_txns_i     completed-transaction target that ends the run
//   cmp_mask_i          per-bit compare enable, packed per channel
//   bus                 monitored src/snk handshakes (slave modport)
//   done_o / fail_o     run finished clean / error seen (registered)
//   state_o             00 IDLE, 01 RUN, 10 DONE, 11 FAIL
//   txn_cnt_o           snk beats with last=1, all channels, saturating
//   mismatch_cnt_o      mismatching snk beats, saturating
//   overflow_o          sticky: push dropped on a full FIFO
//   underflow_o         sticky: pop seen on an empty FIFO
//   fill_o              per-channel FIFO occupancy
// ---------------------------------------------------------------------------

// Per-channel FIFO plus compare. All outputs except the fill are
// combinational event strobes for the current cycle; i_push/i_pop arrive
// already qualified by the scoreboard state.
module axi_chan_scoreboard_lane #(
    parameter int DataWidth = 64,
    parameter int Depth     = 16
) (
    input  logic                     i_clk,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DataWidth-1:0]     i_src_data,
    input  logic [DataWidth-1:0]     i_snk_data,
    input  logic [DataWidth-1:0]     i_mask,
    output logic                     o_mismatch,
    output logic                     o_overflow,
    output logic                     o_underflow,
    output logic                     o_empty,
    output logic [$clog2(Depth):0]   o_fill
);
    localparam int AddrW = $clog2(Depth);
    localparam logic [AddrW:0] PtrOne = 1;

    logic [DataWidth-1:0] r_mem [Depth];
    logic [AddrW:0]       r_wr;
    logic [AddrW:0]       r_rd;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_bypass;
    logic                 w_wr_en;
    logic                 w_rd_en;
    logic [DataWidth-1:0] w_head;
    logic [DataWidth-1:0] w_cmp_data;

    // Pointers carry a wrap bit: equal -> empty, equal except MSB -> full.
    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AddrW] != r_rd[AddrW]) &&
                     (r_wr[AddrW-1:0] == r_rd[AddrW-1:0]);
    assign w_head  = r_mem[r_rd[AddrW-1:0]];

    // Push+pop into an empty FIFO never touches storage: the beat passes
    // straight through and is compared against the live src data.
    assign w_bypass = i_push & i_pop & w_empty;
    // On a full FIFO a simultaneous pop frees the slot being written, so the
    // write lands in the head slot after the head has been read this cycle.
    assign w_wr_en  = i_push & ~w_bypass & (~w_full | i_pop);
    assign w_rd_en  = i_pop & ~w_empty;

    assign o_overflow  = i_push & w_full & ~i_pop;
    assign o_underflow = i_pop & w_empty & ~i_push;

    assign w_cmp_data = w_empty ? i_src_data : w_head;
    assign o_mismatch = i_pop & (~w_empty | i_push) &
                        (|((w_cmp_data ^ i_snk_data) & i_mask));

    assign o_empty = w_empty;
    assign o_fill  = r_wr - r_rd;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + PtrOne;
            if (w_rd_en) r_rd <= r_rd + PtrOne;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers alone.
    always_ff @(posedge i_clk) begin
        if (w_wr_en && !i_clr) r_mem[r_wr[AddrW-1:0]] <= i_src_data;
    end
endmodule

module axi_chan_scoreboard #(
    parameter int NumChan     = 5,
    parameter int DataWidth   = 64,
    parameter int Depth       = 16,
    parameter int CntWidth    = 32,
    parameter bit StopOnError = 1'b0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              enable_i,
    input  logic [CntWidth-1:0]               expected_txns_i,
    input  logic [NumChan*DataWidth-1:0]      cmp_mask_i,
    axi_chan_scoreboard_if.slave              bus,
    output logic                              done_o,
    output logic                              fail_o,
    output logic [1:0]                        state_o,
    output logic [CntWidth-1:0]               txn_cnt_o,
    output logic [CntWidth-1:0]               mismatch_cnt_o,
    output logic [NumChan-1:0]                overflow_o,
    output logic [NumChan-1:0]                underflow_o,
    output logic [NumChan*$clog2(Depth+1)-1:0] fill_o
);
    localparam int FillW = $clog2(Depth+1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10,
        S_FAIL = 2'b11
    } state_t;

    state_t              r_state;
    logic                r_done;
    logic                r_fail;
    logic [CntWidth-1:0] r_txn;
    logic [CntWidth-1:0] r_mis;
    logic [NumChan-1:0]  r_ovf;
    logic [NumChan-1:0]  r_unf;

    logic                w_active;
    logic                w_clr;
    logic [NumChan-1:0]  w_push;
    logic [NumChan-1:0]  w_pop;
    logic [NumChan-1:0]  w_mis;
    logic [NumChan-1:0]  w_ovf;
    logic [NumChan-1:0]  w_unf;
    logic [NumChan-1:0]  w_empty;
    logic                w_err;
    logic [CntWidth-1:0] w_txn_inc;
    logic [CntWidth-1:0] w_mis_inc;

    function automatic logic [CntWidth-1:0] sat_add(
        input logic [CntWidth-1:0] a,
        input logic [CntWidth-1:0] b
    );
        logic [CntWidth:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CntWidth] ? '1 : s[CntWidth-1:0];
    endfunction

    // FAIL keeps monitoring unless the run is meant to freeze on error.
    assign w_active = (r_state == S_RUN) || (!StopOnError && (r_state == S_FAIL));
    assign w_clr    = rst_i | ~enable_i;
    assign w_push   = {NumChan{w_active}} & bus.src_valid & bus.src_ready;
    assign w_pop    = {NumChan{w_active}} & bus.snk_valid & bus.snk_ready;

    for (genvar c = 0; c < NumChan; c++) begin : g_lane
        axi_chan_scoreboard_lane #(
            .DataWidth (DataWidth),
            .Depth     (Depth)
        ) u_lane (
            .i_clk       (clk_i),
            .i_clr       (w_clr),
            .i_push      (w_push[c]),
            .i_pop       (w_pop[c]),
            .i_src_data  (bus.src_data[c*DataWidth +: DataWidth]),
            .i_snk_data  (bus.snk_data[c*DataWidth +: DataWidth]),
            .i_mask      (cmp_mask_i[c*DataWidth +: DataWidth]),
            .o_mismatch  (w_mis[c]),
            .o_overflow  (w_ovf[c]),
            .o_underflow (w_unf[c]),
            .o_empty     (w_empty[c]),
            .o_fill      (fill_o[c*FillW +: FillW])
        );
    end

    // Popcounts: several channels may close a transaction or mismatch in the
    // same cycle.
    always_comb begin
        w_txn_inc = '0;
        w_mis_inc = '0;
        for (int c = 0; c < NumChan; c++) begin
            w_txn_inc = w_txn_inc + CntWidth'(w_pop[c] & bus.snk_last[c]);
            w_mis_inc = w_mis_inc + CntWidth'(w_mis[c]);
        end
    end

    assign w_err = (|w_mis) | (|w_ovf) | (|w_unf);

    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
            r_txn   <= '0;
            r_mis   <= '0;
            r_ovf   <= '0;
            r_unf   <= '0;
        end else begin
            // Event strobes are already zero whenever monitoring is inactive.
            r_txn <= sat_add(r_txn, w_txn_inc);
            r_mis <= sat_add(r_mis, w_mis_inc);
            r_ovf <= r_ovf | w_ovf;
            r_unf <= r_unf | w_unf;
            case (r_state)
                S_IDLE: r_state <= S_RUN;
                S_RUN: begin
                    if (w_err) begin
                        r_state <= S_FAIL;
                        r_fail  <= 1'b1;
                    end else if ((r_txn >= expected_txns_i) && (&w_empty)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_o        = r_state;
    assign done_o         = r_done;
    assign fail_o         = r_fail;
    assign txn_cnt_o      = r_txn;
    assign mismatch_cnt_o = r_mis;
    assign overflow_o     = r_ovf;
    assign underflow_o    = r_unf;
endmodule

// File: tb/tb_axi_chan_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_axi_chan_scoreboard
// Directed bench: reset/idle, random in-order traffic through a 2-cycle pipe
// (clean, corrupted, corrupted-but-masked), bypass, full/overflow,
// underflow, mid-run flush, zero-target run and reset priority.
// ---------------------------------------------------------------------------
module tb_axi_chan_scoreboard;
    localparam int NC  = 5;
    localparam int DW  = 16;
    localparam int DEP = 4;
    localparam int CW  = 32;
    localparam int FW  = $clog2(DEP+1);
    localparam int BEATS = 100;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [CW-1:0]     exp_txns;
    logic [NC*DW-1:0]  mask;
    logic              done;
    logic              fail;
    logic [1:0]        st;
    logic [CW-1:0]     txn;
    logic [CW-1:0]     mis;
    logic [NC-1:0]     ovf;
    logic [NC-1:0]     unf;
    logic [NC*FW-1:0]  fill;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        int unsigned txn;
        int unsigned mis;
        bit          fl;
    } exp_t;
    exp_t eq[$];

    axi_chan_scoreboard_if #(.NumChan(NC), .DataWidth(DW)) bus ();

    axi_chan_scoreboard #(
        .NumChan(NC), .DataWidth(DW), .Depth(DEP), .CntWidth(CW), .StopOnError(1'b0)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (en),
        .expected_txns_i (exp_txns),
        .cmp_mask_i      (mask),
        .bus             (bus),
        .done_o          (done),
        .fail_o          (fail),
        .state_o         (st),
        .txn_cnt_o       (txn),
        .mismatch_cnt_o  (mis),
        .overflow_o      (ovf),
        .underflow_o     (unf),
        .fill_o          (fill)
    );

    always #5 clk = ~clk;

    task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bus();
        bus.src_valid = '0;
        bus.src_ready = '0;
        bus.src_data  = '0;
        bus.snk_valid = '0;
        bus.snk_ready = '0;
        bus.snk_data  = '0;
        bus.snk_last  = '0;
    endtask

    function automatic logic [FW-1:0] fill_of(input int c);
        return fill[c*FW +: FW];
    endfunction

    task automatic src_beat(input int c, input logic [DW-1:0] d);
        bus.src_valid[c] = 1'b1;
        bus.src_ready[c] = 1'b1;
        bus.src_data[c*DW +: DW] = d;
    endtask

    task automatic snk_beat(input int c, input logic [DW-1:0] d, input logic last);
        bus.snk_valid[c] = 1'b1;
        bus.snk_ready[c] = 1'b1;
        bus.snk_data[c*DW +: DW] = d;
        bus.snk_last[c] = last;
    endtask

    // Flush, program the run, and arm: state is RUN on return.
    task automatic arm(input logic [CW-1:0] target);
        idle_bus();
        en = 1'b0;
        step();
        exp_txns = target;
        en = 1'b1;
        step();
        ck("arm_state", 64'(st), 64'(2'b01));
    endtask

    // 100 beats per channel through a 2-stage pipe; snk_last every 4th beat.
    // Expected counters are queued when a snk beat is driven and compared
    // after the edge that registers them.
    task automatic run_traffic(input bit corrupt);
        int          sent [NC];
        logic        p0v [NC], p1v [NC], p0l [NC], p1l [NC], p0b [NC], p1b [NC];
        logic [DW-1:0] p0d [NC], p1d [NC];
        logic [DW-1:0] d;
        int unsigned m_txn;
        int unsigned m_mis;
        int          cyc;
        bit          fin;
        exp_t        e;
        m_txn = 0;
        m_mis = 0;
        cyc   = 0;
        for (int c = 0; c < NC; c++) begin
            sent[c] = 0;
            p0v[c] = 0; p1v[c] = 0; p0l[c] = 0; p1l[c] = 0; p0b[c] = 0; p1b[c] = 0;
            p0d[c] = '0; p1d[c] = '0;
        end
        forever begin
            if (eq.size() != 0) begin
                e = eq.pop_front();
                ck("run_txn", 64'(txn), 64'(e.txn));
                ck("run_mis", 64'(mis), 64'(e.mis));
                ck("run_fail", 64'(fail), 64'(e.fl));
            end
            fin = 1'b1;
            for (int c = 0; c < NC; c++)
                if (sent[c] < BEATS || p0v[c] || p1v[c]) fin = 1'b0;
            if (fin || cyc >= 2000) break;
            idle_bus();
            for (int c = 0; c < NC; c++) begin
                bus.snk_ready[c] = 1'b1;
                bus.src_ready[c] = 1'b1;
                if (p1v[c]) begin
                    snk_beat(c, p1d[c], p1l[c]);
                    if (p1l[c]) m_txn++;
                    if (p1b[c] && mask[c*DW+3]) m_mis++;
                end
                p1v[c] = p0v[c]; p1d[c] = p0d[c]; p1l[c] = p0l[c]; p1b[c] = p0b[c];
                p0v[c] = 1'b0;
                if (sent[c] < BEATS && $urandom_range(0, 1) == 1) begin
                    d = DW'($urandom);
                    src_beat(c, d);
                    p0v[c] = 1'b1;
                    p0l[c] = (sent[c] % 4 == 3);
                    p0b[c] = corrupt && (c == 2) && (sent[c] == 7);
                    p0d[c] = p0b[c] ? (d ^ 16'h0008) : d;
                    sent[c]++;
                end
            end
            e.txn = m_txn;
            e.mis = m_mis;
            e.fl  = (m_mis != 0);
            eq.push_back(e);
            step();
            cyc++;
        end
        ck("run_completed", 64'(fin), 64'(1));
        idle_bus();
        step();
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        exp_txns = '0;
        mask     = '1;
        idle_bus();
        step(3);
        ck("rst_state", 64'(st), 64'(2'b00));
        ck("rst_txn", 64'(txn), 64'(0));
        ck("rst_mis", 64'(mis), 64'(0));
        ck("rst_fill", 64'(fill), 64'(0));
        ck("rst_done", 64'(done), 64'(0));
        ck("rst_fail", 64'(fail), 64'(0));
        ck("rst_ovf", 64'(ovf), 64'(0));
        ck("rst_unf", 64'(unf), 64'(0));

        // Disabled: traffic must be ignored.
        rst = 1'b0;
        bus.src_valid = '1; bus.src_ready = '1; bus.src_data = '1;
        bus.snk_valid = '1; bus.snk_ready = '1; bus.snk_last = '1;
        step(3);
        ck("dis_state", 64'(st), 64'(2'b00));
        ck("dis_fill", 64'(fill), 64'(0));
        ck("dis_txn", 64'(txn), 64'(0));
        ck("dis_unf", 64'(unf), 64'(0));

        // Clean run.
        arm(125);
        run_traffic(1'b0);
        ck("clean_state", 64'(st), 64'(2'b10));
        ck("clean_done", 64'(done), 64'(1));
        ck("clean_txn", 64'(txn), 64'(125));
        ck("clean_mis", 64'(mis), 64'(0));

        // Corrupted beat: counting continues in FAIL.
        arm(125);
        run_traffic(1'b1);
        ck("corr_state", 64'(st), 64'(2'b11));
        ck("corr_fail", 64'(fail), 64'(1));
        ck("corr_done", 64'(done), 64'(0));
        ck("corr_mis", 64'(mis), 64'(1));
        ck("corr_txn", 64'(txn), 64'(125));

        // Same corruption hidden by the compare mask.
        mask[2*DW+3] = 1'b0;
        arm(125);
        run_traffic(1'b1);
        ck("mask_state", 64'(st), 64'(2'b10));
        ck("mask_fail", 64'(fail), 64'(0));
        ck("mask_mis", 64'(mis), 64'(0));
        mask = '1;

        // Bypass on empty channel 0.
        arm(1000);
        src_beat(0, 16'h00A5);
        snk_beat(0, 16'h00A5, 1'b0);
        step();
        idle_bus();
        ck("byp_fill0", 64'(fill_of(0)), 64'(0));
        ck("byp_mis", 64'(mis), 64'(0));
        ck("byp_state", 64'(st), 64'(2'b01));
        ck("byp_unf", 64'(unf), 64'(0));

        // Fill channel 1 to Depth, then overflow.
        for (int i = 0; i < 5; i++) begin
            src_beat(1, DW'(16'h0100 + i));
            step();
            idle_bus();
            if (i == 3) begin
                ck("full_fill1", 64'(fill_of(1)), 64'(4));
                ck("full_ovf", 64'(ovf), 64'(0));
                ck("full_state", 64'(st), 64'(2'b01));
            end
        end
        ck("ovf_fill1", 64'(fill_of(1)), 64'(4));
        ck("ovf_flag", 64'(ovf), 64'(5'b00010));
        ck("ovf_state", 64'(st), 64'(2'b11));
        ck("ovf_fail", 64'(fail), 64'(1));
        // Push+pop while full: head 0x100 leaves, 0x105 joins the tail.
        src_beat(1, 16'h0105);
        snk_beat(1, 16'h0100, 1'b0);
        step();
        idle_bus();
        ck("fullpp_fill1", 64'(fill_of(1)), 64'(4));
        ck("fullpp_mis", 64'(mis), 64'(0));
        begin
            logic [DW-1:0] drain [4];
            drain[0] = 16'h0101; drain[1] = 16'h0102; drain[2] = 16'h0103; drain[3] = 16'h0105;
            for (int i = 0; i < 4; i++) begin
                snk_beat(1, drain[i], 1'b0);
                step();
                idle_bus();
                ck("drain_fill1", 64'(fill_of(1)), 64'(3 - i));
            end
        end
        ck("drain_mis", 64'(mis), 64'(0));
        ck("drain_unf", 64'(unf), 64'(0));

        // Underflow on channel 4.
        arm(1000);
        snk_beat(4, 16'h1234, 1'b0);
        step();
        idle_bus();
        ck("unf_flag", 64'(unf), 64'(5'b10000));
        ck("unf_mis", 64'(mis), 64'(0));
        ck("unf_state", 64'(st), 64'(2'b11));

        // Flush mid-run with fill 3 on channel 3 and one completed txn.
        arm(1000);
        src_beat(0, 16'h0042);
        snk_beat(0, 16'h0042, 1'b1);
        for (int i = 0; i < 3; i++) begin
            src_beat(3, DW'(16'h0300 + i));
            step();
            idle_bus();
        end
        ck("pre_flush_fill3", 64'(fill_of(3)), 64'(3));
        ck("pre_flush_txn", 64'(txn), 64'(1));
        ck("pre_flush_state", 64'(st), 64'(2'b01));
        en = 1'b0;
        step();
        ck("flush_fill", 64'(fill), 64'(0));
        ck("flush_txn", 64'(txn), 64'(0));
        ck("flush_state", 64'(st), 64'(2'b00));

        // Zero target: DONE on the first RUN cycle with empty FIFOs.
        arm(0);
        step();
        ck("zero_state", 64'(st), 64'(2'b10));
        ck("zero_done", 64'(done), 64'(1));

        // Reset beats enable and traffic in the same cycle.
        rst = 1'b1;
        src_beat(0, 16'h0001);
        step();
        idle_bus();
        ck("rstwin_state", 64'(st), 64'(2'b00));
        ck("rstwin_done", 64'(done), 64'(0));
        ck("rstwin_fill", 64'(fill), 64'(0));
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
